// File: rtl/rns_pkg.sv
// Shared constants and state encoding for the RNS modular-add scheduler.
// Residues are 6 bits wide; legal moduli lie in [MOD_MIN, MOD_MAX].
package rns_pkg;

  localparam int RNS_W   = 6;
  localparam int MOD_MIN = 2;
  localparam int MOD_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RED  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rns_modadd_sched_adder.sv
// 6-bit carry-lookahead adder shared by all RNS channels.
// Every carry is a flat generate/propagate product, not a ripple chain.
module Adder_6_BIT (
  input  logic [5:0] i_a,
  input  logic [5:0] i_b,
  output logic [5:0] o_sum,
  output logic       o_cout
);

  logic [5:0] w_g;
  logic [5:0] w_p;
  logic [6:0] w_c;
  logic       w_t;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c = '0;
    w_t = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_c[i+1] = w_g[i];
      for (int j = 0; j < i; j++) begin
        w_t = w_g[j];
        for (int k = j + 1; k <= i; k++) begin
          w_t = w_t & w_p[k];
        end
        w_c[i+1] = w_c[i+1] | w_t;
      end
    end
  end

  assign o_sum  = w_p ^ w_c[5:0];
  assign o_cout = w_c[6];

endmodule

// File: rtl/rns_modadd_sched.sv
// Round-robin scheduler sharing one 6-bit adder among RNS channels.
// Each grant runs a+b, then a conditional subtract of m, then responds.
module rns_modadd_sched
  import rns_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [RNS_W*N_REQ-1:0] req_a,
  input  logic [RNS_W*N_REQ-1:0] req_b,
  input  logic [RNS_W*N_REQ-1:0] req_m,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [RNS_W-1:0]       resp_result,
  output logic                   resp_err,
  output logic                   busy
);

  state_t           r_state;
  state_t           w_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [RNS_W-1:0] r_a;
  logic [RNS_W-1:0] r_b;
  logic [RNS_W-1:0] r_m;
  logic [RNS_W-1:0] r_s;
  logic             r_err;

  logic             w_found;
  logic [ID_W-1:0]  w_gnt;
  logic [ID_W-1:0]  w_cand;
  logic [ID_W-1:0]  w_ptr_nxt;
  int               w_idx;
  logic [RNS_W-1:0] w_a;
  logic [RNS_W-1:0] w_b;
  logic [RNS_W-1:0] w_m;
  logic             w_err;
  logic [RNS_W-1:0] w_negm;
  logic [RNS_W-1:0] w_add_a;
  logic [RNS_W-1:0] w_add_b;
  logic [RNS_W-1:0] w_sum;
  logic             w_cout;

  // Walk from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    w_idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_cand = ID_W'(w_idx);
      if (req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  assign w_ptr_nxt = (int'(w_gnt) == N_REQ - 1) ? '0 : w_gnt + 1'b1;

  assign w_a = req_a[RNS_W*int'(w_gnt) +: RNS_W];
  assign w_b = req_b[RNS_W*int'(w_gnt) +: RNS_W];
  assign w_m = req_m[RNS_W*int'(w_gnt) +: RNS_W];

  assign w_err = (w_m < RNS_W'(MOD_MIN)) | (w_m > RNS_W'(MOD_MAX)) |
                 (w_a >= w_m) | (w_b >= w_m);

  assign w_negm = ~r_m + 6'd1;

  Adder_6_BIT u_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_nxt = ADD;
      ADD:     w_nxt = RED;
      RED:     w_nxt = DONE;
      DONE:    if (resp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    w_add_a   = '0;
    w_add_b   = '0;
    busy      = (r_state != IDLE);
    unique case (r_state)
      IDLE: if (w_found && rst_n) req_ready[w_gnt] = 1'b1;
      ADD: begin
        w_add_a = r_a;
        w_add_b = r_b;
      end
      RED: begin
        w_add_a = r_s;
        w_add_b = w_negm;
      end
      default: ;
    endcase
  end

  // Carry out of s + (64-m) is set exactly when s >= m.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_m         <= '0;
      r_s         <= '0;
      r_err       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_found) begin
          r_a   <= w_a;
          r_b   <= w_b;
          r_m   <= w_m;
          r_id  <= w_gnt;
          r_err <= w_err;
          r_ptr <= w_ptr_nxt;
        end
        ADD: r_s <= w_sum;
        RED: begin
          resp_result <= r_err ? '0 : (w_cout ? w_sum : r_s);
          resp_err    <= r_err;
          resp_id     <= r_id;
          resp_valid  <= 1'b1;
        end
        DONE: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_modadd_sched.sv
// Scoreboard bench for rns_modadd_sched with directed vectors.
// Expected responses are queued at request handshake, checked at response.
module tb_rns_modadd_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [6*N-1:0] req_a = '0;
  logic [6*N-1:0] req_b = '0;
  logic [6*N-1:0] req_m = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [1:0]     resp_id;
  logic [5:0]     resp_result;
  logic           resp_err;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];
  int         glog[$];
  logic [5:0] exp_r[N];
  logic       exp_e[N];

  always #5 clk = ~clk;

  rns_modadd_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_m       (req_m),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Request-side monitor: push hand-computed expectation at handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back({2'(i), exp_r[i], exp_e[i]});
          glog.push_back(i);
        end
      end
    end
  end

  // Response-side monitor.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_id", resp_id, e[8:7]);
        chk("resp_result", resp_result, e[6:1]);
        chk("resp_err", resp_err, e[0]);
      end
    end
  end

  task automatic issue(input int i, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] m, input logic [5:0] r, input logic e);
    bit got;
    got = 1'b0;
    req_a[6*i +: 6] = a;
    req_b[6*i +: 6] = b;
    req_m[6*i +: 6] = m;
    exp_r[i] = r;
    exp_e[i] = e;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    chk("issue_accept", int'(got), 1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", int'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_g[5];
    logic [1:0] h_id;
    logic [5:0] h_res;
    logic h_err;
    exp_g = '{0, 1, 2, 3, 0};

    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_err", resp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request, latency
    issue(0, 6'd5, 6'd9, 6'd11, 6'd3, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_latency", n, 3);
    drain();

    // No wrap and boundary
    @(posedge clk); #1;
    issue(2, 6'd4, 6'd3, 6'd31, 6'd7, 1'b0);
    issue(1, 6'd31, 6'd31, 6'd32, 6'd30, 1'b0);
    drain();

    // All valid from reset: rotation
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    glog.delete();
    fork
      begin
        issue(0, 6'd10, 6'd20, 6'd25, 6'd5, 1'b0);
        issue(0, 6'd12, 6'd12, 6'd13, 6'd11, 1'b0);
      end
      issue(1, 6'd0, 6'd0, 6'd2, 6'd0, 1'b0);
      issue(2, 6'd1, 6'd1, 6'd3, 6'd2, 1'b0);
      issue(3, 6'd16, 6'd16, 6'd17, 6'd15, 1'b0);
    join
    drain();
    chk("t3_grants", glog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) chk("t3_order", glog[i], exp_g[i]);
    end

    // Backpressure
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue(1, 6'd20, 6'd15, 6'd30, 6'd5, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid", resp_valid, 1);
    h_id = resp_id;
    h_res = resp_result;
    h_err = resp_err;
    fork
      issue(3, 6'd2, 6'd3, 6'd7, 6'd5, 1'b0);
    join_none
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", resp_valid, 1);
      chk("t4_hold_id", resp_id, h_id);
      chk("t4_hold_res", resp_result, h_res);
      chk("t4_hold_err", resp_err, h_err);
      chk("t4_busy", busy, 1);
      chk("t4_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_after_valid", resp_valid, 0);
    chk("t4_after_busy", busy, 0);
    wait fork;
    drain();

    // Illegal inputs, then a legal one
    @(posedge clk); #1;
    issue(0, 6'd3, 6'd4, 6'd40, 6'd0, 1'b1);
    issue(1, 6'd7, 6'd1, 6'd7, 6'd0, 1'b1);
    issue(2, 6'd0, 6'd0, 6'd1, 6'd0, 1'b1);
    issue(3, 6'd6, 6'd6, 6'd9, 6'd3, 1'b0);
    drain();

    // Reset while in RED
    @(posedge clk); #1;
    issue(2, 6'd1, 6'd2, 6'd5, 6'd3, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_resp_id", resp_id, 0);
    chk("t6_resp_result", resp_result, 0);
    chk("t6_resp_err", resp_err, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("t6_no_resp", n, 0);
    glog.delete();
    @(posedge clk); #1;
    fork
      issue(3, 6'd5, 6'd5, 6'd6, 6'd4, 1'b0);
      issue(0, 6'd2, 6'd2, 6'd3, 6'd1, 1'b0);
    join
    drain();
    chk("t6_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
